// File: rtl/axi_rd_arbiter.sv
// axi_rd_arbiter: two-master round-robin AR/R arbiter, one outstanding read, sticky beat-count check
// Ports: aclk/aresetn clock and async active-low reset; m0_*/m1_* master AR inputs, AR ready,
// R outputs and R ready; s_* shared slave AR/R port; grant = current/last granted master,
// busy = transaction in progress, burst_err = sticky beat-count mismatch.
module axi_rd_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64,
  parameter int ID_W   = 4
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic [ADDR_W-1:0] m0_araddr,
  input  logic [ID_W-1:0]   m0_arid,
  input  logic [7:0]        m0_arlen,
  input  logic [2:0]        m0_arsize,
  input  logic [1:0]        m0_arburst,
  input  logic              m0_arvalid,
  output logic              m0_arready,
  output logic [DATA_W-1:0] m0_rdata,
  output logic [ID_W-1:0]   m0_rid,
  output logic [1:0]        m0_rresp,
  output logic              m0_rlast,
  output logic              m0_rvalid,
  input  logic              m0_rready,
  input  logic [ADDR_W-1:0] m1_araddr,
  input  logic [ID_W-1:0]   m1_arid,
  input  logic [7:0]        m1_arlen,
  input  logic [2:0]        m1_arsize,
  input  logic [1:0]        m1_arburst,
  input  logic              m1_arvalid,
  output logic              m1_arready,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [ID_W-1:0]   m1_rid,
  output logic [1:0]        m1_rresp,
  output logic              m1_rlast,
  output logic              m1_rvalid,
  input  logic              m1_rready,
  output logic [ADDR_W-1:0] s_araddr,
  output logic [ID_W-1:0]   s_arid,
  output logic [7:0]        s_arlen,
  output logic [2:0]        s_arsize,
  output logic [1:0]        s_arburst,
  output logic              s_arvalid,
  input  logic              s_arready,
  input  logic [DATA_W-1:0] s_rdata,
  input  logic [ID_W-1:0]   s_rid,
  input  logic [1:0]        s_rresp,
  input  logic              s_rlast,
  input  logic              s_rvalid,
  output logic              s_rready,
  output logic              grant,
  output logic              busy,
  output logic              burst_err
);
  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;
  state_t     r_state;
  logic       r_grant, r_ptr, r_err;
  logic [7:0] r_beat, r_len;
  logic       w_arb, w_addr, w_data, w_beat;
  // both requesting: the pointer decides; otherwise whichever master is asking
  assign w_arb  = (m0_arvalid & m1_arvalid) ? r_ptr : m1_arvalid;
  assign w_addr = r_state == ADDR;
  assign w_data = r_state == DATA;
  assign w_beat = s_rvalid & s_rready;
  // payload source follows the registered grant only
  assign s_araddr   = r_grant ? m1_araddr  : m0_araddr;
  assign s_arid     = r_grant ? m1_arid    : m0_arid;
  assign s_arlen    = r_grant ? m1_arlen   : m0_arlen;
  assign s_arsize   = r_grant ? m1_arsize  : m0_arsize;
  assign s_arburst  = r_grant ? m1_arburst : m0_arburst;
  assign s_arvalid  = w_addr & (r_grant ? m1_arvalid : m0_arvalid);
  assign m0_arready = w_addr & ~r_grant & s_arready;
  assign m1_arready = w_addr & r_grant & s_arready;
  assign s_rready   = w_data & (r_grant ? m1_rready : m0_rready);
  assign m0_rvalid  = w_data & ~r_grant & s_rvalid;
  assign m1_rvalid  = w_data & r_grant & s_rvalid;
  assign m0_rdata   = s_rdata;
  assign m0_rid     = s_rid;
  assign m0_rresp   = s_rresp;
  assign m0_rlast   = s_rlast;
  assign m1_rdata   = s_rdata;
  assign m1_rid     = s_rid;
  assign m1_rresp   = s_rresp;
  assign m1_rlast   = s_rlast;
  assign grant      = r_grant;
  assign busy       = r_state != IDLE;
  assign burst_err  = r_err;
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state <= IDLE;
      r_grant <= 1'b0;
      r_ptr   <= 1'b0;
      r_err   <= 1'b0;
      r_beat  <= 8'd0;
      r_len   <= 8'd0;
    end else begin
      case (r_state)
        IDLE: if (m0_arvalid | m1_arvalid) begin
          r_grant <= w_arb;
          r_state <= ADDR;
        end
        ADDR: if (s_arvalid & s_arready) begin
          r_len   <= s_arlen;
          r_beat  <= 8'd0;
          r_state <= DATA;
        end
        DATA: if (w_beat) begin
          if (s_rlast) begin
            r_err   <= r_err | (r_beat != r_len);
            r_ptr   <= ~r_grant;
            r_state <= IDLE;
          end else begin
            // a non-final beat once len_q beats are already counted means an overlong burst
            r_err  <= r_err | (r_beat == r_len);
            r_beat <= r_beat + {7'd0, r_beat != 8'hff};
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_axi_rd_arbiter.sv
// tb_axi_rd_arbiter: directed bench with a transaction-level model checked every cycle
module tb_axi_rd_arbiter;
  logic        aclk = 1'b0;
  logic        aresetn;
  logic [31:0] m0_araddr, m1_araddr, s_araddr;
  logic [3:0]  m0_arid, m1_arid, s_arid;
  logic [7:0]  m0_arlen, m1_arlen, s_arlen;
  logic [2:0]  m0_arsize, m1_arsize, s_arsize;
  logic [1:0]  m0_arburst, m1_arburst, s_arburst;
  logic        m0_arvalid, m0_arready, m1_arvalid, m1_arready, s_arvalid, s_arready;
  logic [63:0] m0_rdata, m1_rdata, s_rdata;
  logic [3:0]  m0_rid, m1_rid, s_rid;
  logic [1:0]  m0_rresp, m1_rresp, s_rresp;
  logic        m0_rlast, m1_rlast, s_rlast;
  logic        m0_rvalid, m1_rvalid, s_rvalid;
  logic        m0_rready, m1_rready, s_rready;
  logic        grant, busy, burst_err;

  int checks = 0, failures = 0, cyc = 0;
  int add0 = 0, add1 = 0, done0 = 0, done1 = 0;
  int cfg_short = 0, cfg_stall = 0;
  bit flush = 0;
  int ar_cyc_q[$], rl_q[$], rq_q[$];
  bit ar_g_q[$];
  int b0 = 0, b1 = 0;
  int base_ar, base_rl, base_rq, base_b0, base_b1;
  bit act = 0, aphase = 0, own = 0, pref = 0, err = 0;
  int n = 0, len = 0;

  axi_rd_arbiter #(.ADDR_W(32), .DATA_W(64), .ID_W(4)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .m0_araddr(m0_araddr), .m0_arid(m0_arid), .m0_arlen(m0_arlen), .m0_arsize(m0_arsize),
    .m0_arburst(m0_arburst), .m0_arvalid(m0_arvalid), .m0_arready(m0_arready),
    .m0_rdata(m0_rdata), .m0_rid(m0_rid), .m0_rresp(m0_rresp), .m0_rlast(m0_rlast),
    .m0_rvalid(m0_rvalid), .m0_rready(m0_rready),
    .m1_araddr(m1_araddr), .m1_arid(m1_arid), .m1_arlen(m1_arlen), .m1_arsize(m1_arsize),
    .m1_arburst(m1_arburst), .m1_arvalid(m1_arvalid), .m1_arready(m1_arready),
    .m1_rdata(m1_rdata), .m1_rid(m1_rid), .m1_rresp(m1_rresp), .m1_rlast(m1_rlast),
    .m1_rvalid(m1_rvalid), .m1_rready(m1_rready),
    .s_araddr(s_araddr), .s_arid(s_arid), .s_arlen(s_arlen), .s_arsize(s_arsize),
    .s_arburst(s_arburst), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rid(s_rid), .s_rresp(s_rresp), .s_rlast(s_rlast),
    .s_rvalid(s_rvalid), .s_rready(s_rready),
    .grant(grant), .busy(busy), .burst_err(burst_err)
  );

  always #5 aclk = ~aclk;
  always @(posedge aclk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act_v, input logic [63:0] exp_v);
    checks++;
    if (act_v !== exp_v) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act_v, exp_v, cyc);
    end
  endtask

  // model: one transaction owns the slave from grant until its final beat;
  // it must deliver exactly arlen+1 beats
  task automatic model_cycle();
    logic [1:0] arv, rr;
    bit ea, ed;
    if (!aresetn) begin
      act = 0; aphase = 0; own = 0; pref = 0; err = 0; n = 0; len = 0;
    end
    arv = {m1_arvalid, m0_arvalid};
    rr  = {m1_rready, m0_rready};
    ea  = act && aphase;
    ed  = act && !aphase;
    chk("s_arvalid", s_arvalid, ea ? arv[own] : 1'b0);
    chk("m0_arready", m0_arready, (ea && !own) ? s_arready : 1'b0);
    chk("m1_arready", m1_arready, (ea && own) ? s_arready : 1'b0);
    chk("s_rready", s_rready, ed ? rr[own] : 1'b0);
    chk("m0_rvalid", m0_rvalid, (ed && !own) ? s_rvalid : 1'b0);
    chk("m1_rvalid", m1_rvalid, (ed && own) ? s_rvalid : 1'b0);
    chk("grant", grant, own);
    chk("busy", busy, act);
    chk("burst_err", burst_err, err);
    chk("m0_rdata", m0_rdata, s_rdata);
    chk("m1_rdata", m1_rdata, s_rdata);
    chk("r_meta", {m0_rid, m0_rresp, m0_rlast, m1_rid, m1_rresp, m1_rlast},
        {s_rid, s_rresp, s_rlast, s_rid, s_rresp, s_rlast});
    if (ea)
      chk("s_ar_payload", {s_araddr, s_arid, s_arlen, s_arsize, s_arburst},
          own ? {m1_araddr, m1_arid, m1_arlen, m1_arsize, m1_arburst}
              : {m0_araddr, m0_arid, m0_arlen, m0_arsize, m0_arburst});
    if (aresetn) begin
      if (!busy && (m0_arvalid || m1_arvalid)) rq_q.push_back(cyc);
      if (s_arvalid && s_arready) begin ar_cyc_q.push_back(cyc); ar_g_q.push_back(grant); end
      if (s_rvalid && s_rready && s_rlast) rl_q.push_back(cyc);
      if (m0_rvalid && m0_rready) b0++;
      if (m1_rvalid && m1_rready) b1++;
    end
    if (!aresetn) begin
    end else if (!act) begin
      if (arv != 2'b00) begin
        own = (arv == 2'b11) ? pref : arv[1];
        act = 1; aphase = 1;
      end
    end else if (aphase) begin
      if (arv[own] && s_arready) begin
        aphase = 0; n = 0; len = own ? int'(m1_arlen) : int'(m0_arlen);
      end
    end else if (s_rvalid && rr[own]) begin
      if (s_rlast) begin
        if (n != len) err = 1;
        act = 0; pref = !own;
      end else begin
        if (n >= len) err = 1;
        n++;
      end
    end
  endtask

  initial forever begin
    @(negedge aclk);
    model_cycle();
  end

  // masters: hold arvalid while requests remain outstanding
  initial begin
    bit h0, h1;
    m0_arvalid = 0; m1_arvalid = 0;
    forever begin
      @(negedge aclk);
      h0 = m0_arvalid && m0_arready;
      h1 = m1_arvalid && m1_arready;
      @(posedge aclk); #2;
      done0 += int'(h0);
      done1 += int'(h1);
      m0_arvalid = add0 > done0;
      m1_arvalid = add1 > done1;
    end
  end

  // slave: optional AR stall, then arlen+1 beats (or cfg_short beats)
  initial begin
    bit ar_hs, r_hs, av;
    logic [7:0] al;
    logic [3:0] rid_q;
    int pending, sent, wait_cnt;
    pending = 0; sent = 0; wait_cnt = 0; rid_q = 0;
    s_arready = 0; s_rvalid = 0; s_rlast = 0; s_rdata = 0; s_rid = 0; s_rresp = 0;
    forever begin
      @(negedge aclk);
      ar_hs = s_arvalid && s_arready;
      r_hs = s_rvalid && s_rready;
      av = s_arvalid;
      al = s_arlen;
      @(posedge aclk); #2;
      if (flush) begin
        pending = 0; sent = 0; wait_cnt = 0;
      end else begin
        if (ar_hs) begin
          pending = cfg_short > 0 ? cfg_short : int'(al) + 1;
          sent = 0; wait_cnt = 0; rid_q = s_arid;
        end else if (av) wait_cnt++;
        if (r_hs) begin
          sent++;
          if (sent == pending) begin pending = 0; sent = 0; end
        end
      end
      s_arready = pending == 0 && wait_cnt >= cfg_stall;
      s_rvalid = pending > 0;
      s_rlast = pending > 0 && sent == pending - 1;
      s_rdata = {28'h0, rid_q, 32'(sent)} ^ 64'hA5A5_0000_5A5A_0000;
      s_rid = rid_q;
      s_rresp = 2'(sent);
    end
  end

  task automatic step(); @(posedge aclk); #1; endtask
  task automatic nstep(); @(negedge aclk); #1; endtask
  task automatic mark();
    base_ar = ar_cyc_q.size(); base_rl = rl_q.size(); base_rq = rq_q.size();
    base_b0 = b0; base_b1 = b1;
  endtask
  task automatic wait_rl(input int cnt, input string nm);
    int t = 0;
    while (rl_q.size() < cnt && t < 300) begin nstep(); t++; end
    chk(nm, rl_q.size() >= cnt, 1);
  endtask
  task automatic do_reset();
    step(); aresetn = 0; flush = 1;
    repeat (2) step();
    aresetn = 1; flush = 0;
    step();
  endtask

  initial begin
    aresetn = 0; m0_rready = 1; m1_rready = 1;
    m0_araddr = 0; m0_arid = 0; m0_arlen = 0; m0_arsize = 3; m0_arburst = 1;
    m1_araddr = 0; m1_arid = 0; m1_arlen = 0; m1_arsize = 3; m1_arburst = 1;
    repeat (3) step();
    aresetn = 1;
    step();
    nstep();
    chk("rst_busy", busy, 0);
    chk("rst_grant", grant, 0);
    chk("rst_burst_err", burst_err, 0);
    chk("rst_s_arvalid", s_arvalid, 0);
    chk("rst_s_rready", s_rready, 0);
    // single m0 read, arlen=3
    mark(); step();
    m0_araddr = 32'h0000_1000; m0_arid = 4'h3; m0_arlen = 8'd3;
    add0 += 1;
    wait_rl(base_rl + 1, "t1_rlast_timeout");
    chk("t1_busy_at_rlast", busy, 1);
    nstep();
    chk("t1_busy_after_rlast", busy, 0);
    chk("t1_m0_beats", b0 - base_b0, 4);
    chk("t1_m1_beats", b1 - base_b1, 0);
    chk("t1_burst_err", burst_err, 0);
    chk("t1_ar_latency", ar_cyc_q[base_ar] - rq_q[base_rq], 1);
    // simultaneous requests after reset: 0, 1, 0
    do_reset(); mark(); step();
    m0_araddr = 32'h0000_2000; m0_arid = 4'h1; m0_arlen = 8'd1;
    m1_araddr = 32'h0000_3000; m1_arid = 4'h5; m1_arlen = 8'd2;
    add0 += 2; add1 += 1;
    wait_rl(base_rl + 3, "t2_rlast_timeout");
    nstep();
    chk("t2_grant0", ar_g_q[base_ar], 0);
    chk("t2_grant1", ar_g_q[base_ar + 1], 1);
    chk("t2_grant2", ar_g_q[base_ar + 2], 0);
    chk("t2_bubble_a", ar_cyc_q[base_ar + 1] - rl_q[base_rl], 2);
    chk("t2_bubble_b", ar_cyc_q[base_ar + 2] - rl_q[base_rl + 1], 2);
    // slave stalls AR while m1 also requests
    mark(); step();
    m0_araddr = 32'h1000_0100; m0_arid = 4'h7; m0_arlen = 8'd0;
    m1_araddr = 32'h2000_0200; m1_arid = 4'h9; m1_arlen = 8'd0;
    cfg_stall = 5; add0 += 1;
    step(); add1 += 1;
    repeat (3) step();
    nstep();
    chk("t3_grant_stalled", grant, 0);
    chk("t3_s_araddr", s_araddr, 32'h1000_0100);
    chk("t3_s_arid", s_arid, 4'h7);
    chk("t3_s_arvalid", s_arvalid, 1);
    chk("t3_m1_arready", m1_arready, 0);
    wait_rl(base_rl + 2, "t3_rlast_timeout");
    step(); cfg_stall = 0;
    chk("t3_order0", ar_g_q[base_ar], 0);
    chk("t3_order1", ar_g_q[base_ar + 1], 1);
    chk("t3_m1_after_m0", ar_cyc_q[base_ar + 1] > rl_q[base_rl], 1);
    // R backpressure: m1 toggles rready over arlen=1
    mark(); step();
    m1_araddr = 32'h0000_4000; m1_arlen = 8'd1;
    add1 += 1;
    for (int i = 0; i < 60 && rl_q.size() < base_rl + 1; i++) begin
      step();
      if (busy) m1_rready = ~m1_rready;
    end
    m1_rready = 1;
    nstep();
    chk("t4_rlast_seen", rl_q.size(), base_rl + 1);
    chk("t4_m1_beats", b1 - base_b1, 2);
    chk("t4_m0_beats", b0 - base_b0, 0);
    chk("t4_idle", busy, 0);
    // short burst sets sticky error
    mark(); step();
    m0_araddr = 32'h0000_5000; m0_arlen = 8'd3; cfg_short = 2;
    add0 += 1;
    wait_rl(base_rl + 1, "t5_rlast_timeout");
    step(); cfg_short = 0;
    nstep();
    chk("t5_err_set", burst_err, 1);
    chk("t5_m0_beats", b0 - base_b0, 2);
    step();
    m1_araddr = 32'h0000_6000; m1_arlen = 8'd0;
    add1 += 1;
    wait_rl(base_rl + 2, "t5_clean_timeout");
    nstep();
    chk("t5_err_sticky", burst_err, 1);
    chk("t5_m1_beats", b1 - base_b1, 1);
    do_reset();
    nstep();
    chk("t5_err_cleared", burst_err, 0);
    // reset during DATA after beat 1
    mark(); step();
    m1_araddr = 32'h0000_7000; m1_arid = 4'hC; m1_arlen = 8'd3;
    add1 += 1;
    for (int t = 0; t < 100 && b1 < base_b1 + 1; t++) nstep();
    chk("t6_beat1_seen", b1 >= base_b1 + 1, 1);
    step();
    aresetn = 0;
    #1;
    chk("t6_s_rready", s_rready, 0);
    chk("t6_m1_rvalid", m1_rvalid, 0);
    chk("t6_m1_arready", m1_arready, 0);
    chk("t6_s_arvalid", s_arvalid, 0);
    chk("t6_busy", busy, 0);
    chk("t6_grant", grant, 0);
    repeat (2) step();
    aresetn = 1;
    repeat (3) step();
    nstep();
    chk("t6_beats_ignored", m1_rvalid, 0);
    chk("t6_still_idle", busy, 0);
    step(); flush = 1;
    step(); flush = 0;
    m1_araddr = 32'h0000_8000; m1_arlen = 8'd3;
    add1 += 1;
    wait_rl(base_rl + 1, "t6_rlast_timeout");
    nstep();
    chk("t6_regrant_m1", ar_g_q[base_ar + 1], 1);
    chk("t6_m1_beats", b1 - base_b1, 5);
    chk("t6_burst_err", burst_err, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    failures++;
    $display("FAIL watchdog time limit reached at cycle %0d", cyc);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end
endmodule
